// File: rtl/accel_pkg.sv
// accel_pkg: shared state encoding and width defaults for the accelerator run controller
package accel_pkg;
  localparam int ADDR_WID_DEF = 14;
  localparam int DATA_WID_DEF = 32;
  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, PREFETCH, STORE, DONE} state_t;
endpackage

// File: rtl/accel_beat_ctr.sv
// accel_beat_ctr: 64-bit DMA beat counter with last-beat compare and truncated scratchpad index
module accel_beat_ctr #(
  parameter int IDX_WID = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  input  logic [63:0]        num,
  output logic [IDX_WID-1:0] idx,
  output logic [IDX_WID-1:0] idx_nx,
  output logic               last
);
  logic [63:0] cnt, cnt_nx;
  assign cnt_nx = cnt + 64'd1;
  assign last = cnt_nx == num;
  assign idx = cnt[IDX_WID-1:0];
  assign idx_nx = cnt_nx[IDX_WID-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt_nx;
endmodule

// File: rtl/accel_run_ctrl.sv
// accel_run_ctrl: DMA load -> kernel run -> DMA store sequencer around a shared scratchpad.
// Optional CYCLE_COUNTER_EN adds a per-run busy-cycle counter; otherwise cycles is tied to 0.
module accel_run_ctrl
  import accel_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int DATA_WID = DATA_WID_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         num_words,
  input  logic [63:0]         word_size,
  input  logic                read_ready,
  input  logic [DATA_WID-1:0] read_data,
  output logic                read_enable,
  output logic [63:0]         read_addr,
  output logic                finish_read,
  input  logic                write_ready,
  output logic                write_enable,
  output logic [63:0]         write_addr,
  output logic [DATA_WID-1:0] write_data,
  output logic                finish_write,
  output logic [ADDR_WID-1:0] spm_addr,
  output logic                spm_we,
  output logic [DATA_WID-1:0] spm_wdata,
  input  logic [DATA_WID-1:0] spm_rdata,
  output logic                kernel_owns_spm,
  output logic                ap_start,
  input  logic                ap_done,
  output logic                done,
  output logic                busy,
  output logic [63:0]         cycles
);
  state_t state, state_nx;
  logic [ADDR_WID-1:0] idx, idx_nx;
  logic last, gap, beat_r, beat_w;
  assign beat_r = state == LOAD && read_ready;
  // gap: the cycle after a store beat waits for the new scratchpad word
  assign beat_w = state == STORE && write_ready && !gap;
  accel_beat_ctr #(.IDX_WID(ADDR_WID)) u_beat (
    .clk,
    .reset,
    .clr(state == IDLE || state == PREFETCH),
    .inc((beat_r || beat_w) && !last),
    .num(num_words),
    .idx,
    .idx_nx,
    .last
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = num_words != 64'd0 ? LOAD : DONE;
      LOAD:     if (beat_r && last) state_nx = KICK;
      KICK:     state_nx = RUN;
      RUN:      if (ap_done) state_nx = PREFETCH;
      PREFETCH: state_nx = STORE;
      STORE:    if (beat_w && last) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    read_enable = state == LOAD;
    write_enable = state == STORE;
    ap_start = state == KICK;
    kernel_owns_spm = state == KICK || state == RUN;
    done = state == DONE;
    spm_we = beat_r;
    spm_wdata = beat_r ? read_data : '0;
    write_data = write_enable ? spm_rdata : '0;
    spm_addr = state == LOAD ? idx : beat_w && !last ? idx_nx : state == STORE ? idx : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      read_addr <= '0;
      write_addr <= '0;
      finish_read <= 1'b0;
      finish_write <= 1'b0;
      gap <= 1'b0;
    end else begin
      finish_read <= beat_r && !last;
      finish_write <= beat_w && !last;
      gap <= beat_w && !last;
      if (state == IDLE && start) read_addr <= read_base;
      else if (beat_r && !last) read_addr <= read_addr + word_size;
      if (state == PREFETCH) write_addr <= write_base;
      else if (beat_w && !last) write_addr <= write_addr + word_size;
    end
`ifdef CYCLE_COUNTER_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) cycles <= '0;
    else if (state == IDLE && start && num_words != 64'd0) cycles <= '0;
    else if (busy && state != DONE) cycles <= cycles + 64'd1;
`else
  assign cycles = '0;
`endif
endmodule

// File: tb/tb_accel_run_ctrl.sv
// tb_accel_run_ctrl: randomized runs checked against an event-level model of load/kick/run/store
module tb_accel_run_ctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int SZ = 1 << AW;
  logic clk = 0, reset = 1, start = 0, read_ready = 0, write_ready = 0, ap_done = 0;
  logic [63:0] read_base = '0, write_base = '0, num_words = '0, word_size = '0;
  logic [DW-1:0] read_data = '0, spm_rdata = '0;
  logic read_enable, finish_read, write_enable, finish_write, spm_we, kernel_owns_spm;
  logic ap_start, done, busy;
  logic [63:0] read_addr, write_addr, cycles;
  logic [DW-1:0] write_data, spm_wdata;
  logic [AW-1:0] spm_addr;
  logic [DW-1:0] mem [SZ];
  logic [DW-1:0] rd_next = '0;
  int n_chk = 0, n_fail = 0;

  accel_run_ctrl #(.ADDR_WID(AW), .DATA_WID(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .read_base(read_base), .write_base(write_base), .num_words(num_words), .word_size(word_size),
    .read_ready(read_ready), .read_data(read_data), .read_enable(read_enable),
    .read_addr(read_addr), .finish_read(finish_read),
    .write_ready(write_ready), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .finish_write(finish_write),
    .spm_addr(spm_addr), .spm_we(spm_we), .spm_wdata(spm_wdata), .spm_rdata(spm_rdata),
    .kernel_owns_spm(kernel_owns_spm), .ap_start(ap_start), .ap_done(ap_done),
    .done(done), .busy(busy), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ctl"}, 64'({read_enable, write_enable, ap_start, finish_read, finish_write,
                              done, busy, kernel_owns_spm, spm_we}), 64'd0);
    check({tag, ".raddr"}, read_addr, 64'd0);
    check({tag, ".waddr"}, write_addr, 64'd0);
    check({tag, ".cycles"}, cycles, 64'd0);
  endtask

  // One complete run seen cycle by cycle; cycle 0 carries start.
  // rmode: 1 = read_ready always high; wmode: 0 random, 1 always, 2 toggling; dmode: 1 = 0xA,0xB,...
  task automatic do_run(input logic [63:0] nw, input logic [63:0] ws, input logic [63:0] rb,
                        input logic [63:0] wb, input int lat, input logic [DW-1:0] kmask,
                        input bit stale, input int rmode, input int wmode, input int dmode);
    logic [DW-1:0] loaded [$];
    logic [DW-1:0] e;
    int rbeats = 0, wbeats = 0, kick = -1, last_r = -1, last_w = -1, done_at = -1;
    bit prev_rfin = 0, prev_wfin = 0, prev_wb = 0, fin = 0, rbeat, wbeat, exp_ren, exp_wen;
    read_base = rb;
    write_base = wb;
    num_words = nw;
    word_size = ws;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(posedge clk);
      #1;
      start = cyc == 0;
      read_ready = rmode == 1 ? 1'b1 : 1'($urandom % 2);
      read_data = dmode == 1 ? DW'(32'hA + 32'(rbeats)) : DW'($urandom);
      write_ready = wmode == 1 ? 1'b1 : wmode == 2 ? 1'(cyc % 2) : 1'($urandom % 2);
      ap_done = (kick >= 0 && cyc == kick + lat) || (stale && ap_start);
      spm_rdata = rd_next;
      #3;
      exp_ren = cyc >= 1 && 64'(rbeats) < nw;
      check("read_enable", 64'(read_enable), 64'(exp_ren));
      check("finish_read", 64'(finish_read), 64'(prev_rfin));
      rbeat = exp_ren && read_ready;
      prev_rfin = 0;
      if (rbeat) begin
        check("read_addr", read_addr, rb + 64'(rbeats) * ws);
        check("spm_we", 64'(spm_we), 64'd1);
        check("spm_addr_load", 64'(spm_addr), 64'(rbeats % SZ));
        check("spm_wdata", 64'(spm_wdata), 64'(read_data));
        loaded.push_back(read_data);
        rbeats++;
        if (64'(rbeats) == nw) last_r = cyc;
        prev_rfin = 64'(rbeats) < nw;
      end else check("spm_we_idle", 64'(spm_we), 64'd0);
      check("ap_start", 64'(ap_start), 64'(last_r >= 0 && cyc == last_r + 1));
      if (last_r >= 0 && cyc == last_r + 1) kick = cyc;
      check("kernel_owns_spm", 64'(kernel_owns_spm), 64'(kick >= 0 && cyc <= kick + lat));
      exp_wen = kick >= 0 && cyc >= kick + lat + 2 && 64'(wbeats) < nw;
      check("write_enable", 64'(write_enable), 64'(exp_wen));
      check("finish_write", 64'(finish_write), 64'(prev_wfin));
      wbeat = exp_wen && write_ready && !prev_wb;
      prev_wb = wbeat;
      prev_wfin = 0;
      if (wbeat) begin
        e = '0;
        for (int j = 0; 64'(j) < nw; j++) if (j % SZ == wbeats % SZ) e = loaded[j];
        check("write_addr", write_addr, wb + 64'(wbeats) * ws);
        check("write_data", 64'(write_data), 64'(e ^ kmask));
        wbeats++;
        if (64'(wbeats) == nw) last_w = cyc;
        prev_wfin = 64'(wbeats) < nw;
      end
      if ((nw == 0 && cyc == 1) || (last_w >= 0 && cyc == last_w + 1)) done_at = cyc;
      check("done", 64'(done), 64'(done_at == cyc));
      check("busy", 64'(busy), 64'(cyc >= 1 && (done_at < 0 || cyc == done_at)));
      if (done_at == cyc) begin
`ifdef CYCLE_COUNTER_EN
        if (nw != 0) check("cycles", cycles, 64'(last_w));
`else
        check("cycles", cycles, 64'd0);
`endif
      end
      if (kick >= 0 && cyc == kick + lat) for (int i = 0; i < SZ; i++) mem[i] = mem[i] ^ kmask;
      rd_next = mem[spm_addr];
      if (spm_we && !kernel_owns_spm) mem[spm_addr] = spm_wdata;
      if (done_at >= 0 && cyc == done_at + 1) fin = 1;
    end
    if (!fin) check("run_timeout", 64'd0, 64'd1);
    start = 0;
    ap_done = 0;
  endtask

  initial begin
    for (int i = 0; i < SZ; i++) mem[i] = DW'($urandom);
    repeat (2) @(posedge clk);
    #4;
    check_quiet("reset");
    @(negedge clk);
    reset = 0;
    do_run(64'd4, 64'd4, 64'h1000, 64'h8000, 10, DW'($urandom), 0, 1, 1, 0);
    do_run(64'd4, 64'd4, 64'h1000, 64'h8000, 10, DW'($urandom), 1, 1, 1, 0);
    do_run(64'd3, 64'd4, 64'h100, 64'h4000, 5, '0, 0, 1, 2, 1);
    do_run(64'd0, 64'd4, 64'h100, 64'h4000, 3, '0, 0, 1, 1, 0);
    do_run(64'd3, 64'd8, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF0, 1, DW'($urandom), 1, 0, 0, 0);
    for (int r = 0; r < 14; r++)
      do_run(64'($urandom_range(1, 11)),
             ($urandom % 3 == 0) ? {$urandom, $urandom} : 64'(1 << ($urandom % 4)),
             ($urandom % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom},
             {$urandom, $urandom}, int'($urandom_range(1, 12)), DW'($urandom),
             1'($urandom % 2), int'($urandom % 2), int'($urandom % 3), 0);
    // abort mid-LOAD after two beats, then a clean rerun must start at read_base again
    read_base = 64'h3000;
    num_words = 64'd4;
    word_size = 64'd4;
    @(posedge clk);
    #1;
    start = 1;
    read_ready = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (2) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1;
    #1;
    check_quiet("abort");
    @(negedge clk);
    reset = 0;
    do_run(64'd4, 64'd4, 64'h3000, 64'h9000, 2, DW'($urandom), 0, 1, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
